// File: rtl/ttlc_io_pkg.sv
// ttlc_io_pkg: shared definitions for the TTLC bit-addressable I/O space.
// Holds the region base addresses, the parameter range limits and the
// address decoder that maps a core bit address to (region, offset).
package ttlc_io_pkg;

  localparam int ADDR_W_REQ = 8;
  localparam int N_OUT_MAX  = 63;
  localparam int N_IN_MAX   = 64;
  localparam int N_SCR_MAX  = 32;
  localparam int N_EDGE_MAX = 16;
  localparam int SYNC_MIN   = 1;
  localparam int SYNC_MAX   = 3;

  localparam logic [7:0] BASE_RR   = 8'h00;
  localparam logic [7:0] BASE_OUT  = 8'h01;
  localparam logic [7:0] BASE_IN   = 8'h40;
  localparam logic [7:0] BASE_SCR  = 8'h80;
  localparam logic [7:0] BASE_PIN  = 8'hA0;
  localparam logic [7:0] BASE_FLAG = 8'hC0;
  localparam logic [7:0] BASE_MASK = 8'hD0;
  localparam logic [7:0] BASE_GIE  = 8'hE0;
  localparam logic [7:0] BASE_PEND = 8'hE1;
  localparam logic [7:0] BASE_POL  = 8'hF0;

  typedef enum logic [3:0] {
    RGN_NONE, RGN_RR, RGN_OUT, RGN_IN, RGN_SCR, RGN_PIN,
    RGN_FLAG, RGN_MASK, RGN_GIE, RGN_PEND, RGN_POL
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [5:0] offset;
  } decode_t;

  // Offset is the bit index within the region; for the output region the
  // address itself is the pin number (pins are numbered from 1).
  function automatic decode_t decode(input logic [7:0] addr);
    decode_t d;
    d.region = RGN_NONE;
    d.offset = addr[5:0];
    if (addr == BASE_RR) begin
      d.region = RGN_RR;
    end else if (addr >= BASE_OUT && addr < BASE_IN) begin
      d.region = RGN_OUT;
    end else if (addr < BASE_SCR) begin
      d.region = RGN_IN;
    end else if (addr < BASE_PIN) begin
      d.region = RGN_SCR;
      d.offset = {1'b0, addr[4:0]};
    end else if (addr < BASE_FLAG) begin
      d.region = RGN_PIN;
      d.offset = {1'b0, addr[4:0]};
    end else if (addr < BASE_MASK) begin
      d.region = RGN_FLAG;
      d.offset = {2'b00, addr[3:0]};
    end else if (addr < BASE_GIE) begin
      d.region = RGN_MASK;
      d.offset = {2'b00, addr[3:0]};
    end else if (addr == BASE_GIE) begin
      d.region = RGN_GIE;
    end else if (addr == BASE_PEND) begin
      d.region = RGN_PEND;
    end else if (addr >= BASE_POL) begin
      d.region = RGN_POL;
      d.offset = {2'b00, addr[3:0]};
    end
    return d;
  endfunction

endpackage

// File: rtl/ttlc_io_ctl_edge.sv
// ttlc_io_edge: one edge-capture channel.
// Synchronises an asynchronous pin, keeps the previous synced value,
// detects the selected edge and holds a sticky flag with W1C clear.
// A new edge in the same cycle as a clear keeps the flag set.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   pin         asynchronous input pin
//   pol         0 = rising edge, 1 = falling edge
//   settled     events are suppressed while low (post-reset settle)
//   clr         write-1-to-clear strobe for this flag
//   sync        synchronised pin value
//   flag        captured edge flag
module ttlc_io_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic pol,
  input  logic settled,
  input  logic clr,
  output logic sync,
  output logic flag
);

  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  logic evt;

  assign sync = chain[SYNC_STAGES-1];
  assign evt  = settled & (pol ? (~sync & prev) : (sync & ~prev));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      flag  <= 1'b0;
    end else begin
      chain[0] <= pin;
      for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
      prev <= sync;
      flag <= evt | (flag & ~clr);
    end
  end

endmodule

// File: rtl/ttlc_io_ctl.sv
// ttlc_io_ctl: bit-addressable I/O space for the MC14500-based TTLC.
// Decodes the 1-bit core's address into outputs, synced inputs, scratch,
// synced parallel port, edge flags/masks/polarity and interrupt control.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   address, mem_write,  core bit address, write strobe, write data
//   data_in
//   rr_value             MC14500 RR, read at address 0
//   input_pins           asynchronous inputs (low N_EDGE have edge capture)
//   output_pins          registered outputs, numbered N_OUT:1
//   data_out             combinational read data
//   port_out / port_in   parallel port (scratch low bits / async input)
//   ttlc_int             registered interrupt = GIE & pending
module ttlc_io_ctl
  import ttlc_io_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int N_OUT       = 47,
  parameter int N_IN        = 48,
  parameter int N_SCR       = 32,
  parameter int PORT_W      = 8,
  parameter int N_EDGE      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_write,
  input  logic              data_in,
  input  logic              rr_value,
  input  logic [N_IN-1:0]   input_pins,
  output logic [N_OUT:1]    output_pins,
  output logic              data_out,
  output logic [PORT_W-1:0] port_out,
  input  logic [PORT_W-1:0] port_in,
  output logic              ttlc_int
);

  if (ADDR_W != ADDR_W_REQ || N_OUT < 1 || N_OUT > N_OUT_MAX ||
      N_IN < 1 || N_IN > N_IN_MAX || N_SCR < 1 || N_SCR > N_SCR_MAX ||
      PORT_W < 1 || PORT_W > N_SCR || N_EDGE < 0 || N_EDGE > N_EDGE_MAX ||
      N_EDGE > N_IN || SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_params
    $error("ttlc_io_ctl: parameter combination out of range");
  end

  // Keep edge vectors at least one bit wide so N_EDGE = 0 still elaborates.
  localparam int NE = (N_EDGE > 0) ? N_EDGE : 1;
  localparam logic [2:0] SETTLE_INIT = 3'(SYNC_STAGES + 1);

  decode_t           dec;
  logic [N_SCR-1:0]  scratch;
  logic [NE-1:0]     flag, mask, pol, flag_clr;
  logic              gie, pending, settled;
  logic [2:0]        settle_cnt;
  logic [N_IN-1:0]   in_sync;
  logic [PORT_W-1:0] port_chain [SYNC_STAGES];

  assign dec      = decode(address);
  assign port_out = scratch[PORT_W-1:0];
  assign pending  = |(flag & mask);
  assign settled  = (settle_cnt == 3'd0);

  always_comb begin
    flag_clr = '0;
    for (int i = 0; i < N_EDGE; i++)
      flag_clr[i] = mem_write & data_in & (dec.region == RGN_FLAG) & (dec.offset == 6'(i));
  end

  if (N_EDGE == 0) begin : g_no_edge
    assign flag = '0;
  end
  for (genvar e = 0; e < N_EDGE; e++) begin : g_edge
    ttlc_io_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin     (input_pins[e]),
      .pol     (pol[e]),
      .settled (settled),
      .clr     (flag_clr[e]),
      .sync    (in_sync[e]),
      .flag    (flag[e])
    );
  end

  // Inputs without edge capture still need their own synchroniser.
  for (genvar i = N_EDGE; i < N_IN; i++) begin : g_in_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chain <= '0;
      end else begin
        chain[0] <= input_pins[i];
        for (int s = 1; s < SYNC_STAGES; s++) chain[s] <= chain[s-1];
      end
    end
    assign in_sync[i] = chain[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) port_chain[s] <= '0;
    end else begin
      port_chain[0] <= port_in;
      for (int s = 1; s < SYNC_STAGES; s++) port_chain[s] <= port_chain[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output_pins <= '0;
      scratch     <= '0;
      mask        <= '0;
      pol         <= '0;
      gie         <= 1'b0;
      ttlc_int    <= 1'b0;
      settle_cnt  <= SETTLE_INIT;
    end else begin
      ttlc_int <= gie & pending;
      if (settle_cnt != 3'd0) settle_cnt <= settle_cnt - 3'd1;
      if (mem_write) begin
        case (dec.region)
          RGN_OUT:
            for (int i = 1; i <= N_OUT; i++)
              if (dec.offset == 6'(i)) output_pins[i] <= data_in;
          RGN_SCR:
            for (int i = 0; i < N_SCR; i++)
              if (dec.offset == 6'(i)) scratch[i] <= data_in;
          RGN_MASK:
            for (int i = 0; i < N_EDGE; i++)
              if (dec.offset == 6'(i)) mask[i] <= data_in;
          RGN_POL:
            for (int i = 0; i < N_EDGE; i++)
              if (dec.offset == 6'(i)) pol[i] <= data_in;
          RGN_GIE: gie <= data_in;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_out = 1'b0;
    case (dec.region)
      RGN_RR: data_out = rr_value;
      RGN_OUT:
        for (int i = 1; i <= N_OUT; i++)
          if (dec.offset == 6'(i)) data_out = output_pins[i];
      RGN_IN:
        for (int i = 0; i < N_IN; i++)
          if (dec.offset == 6'(i)) data_out = in_sync[i];
      RGN_SCR:
        for (int i = 0; i < N_SCR; i++)
          if (dec.offset == 6'(i)) data_out = scratch[i];
      RGN_PIN:
        for (int i = 0; i < PORT_W; i++)
          if (dec.offset == 6'(i)) data_out = port_chain[SYNC_STAGES-1][i];
      RGN_FLAG:
        for (int i = 0; i < N_EDGE; i++)
          if (dec.offset == 6'(i)) data_out = flag[i];
      RGN_MASK:
        for (int i = 0; i < N_EDGE; i++)
          if (dec.offset == 6'(i)) data_out = mask[i];
      RGN_GIE:  data_out = gie;
      RGN_PEND: data_out = pending;
      RGN_POL:
        for (int i = 0; i < N_EDGE; i++)
          if (dec.offset == 6'(i)) data_out = pol[i];
      default: ;
    endcase
  end

endmodule
